// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle shift sequencer, 2 bits per clock plus an optional final 1-bit step
//
// Purpose: shift-by-N for the SimpleProcessor datapath without a combinational
// barrel shifter. The operand is shifted in place in o_data, two bits per
// clock, with a single 1-bit step at the end when the amount is odd.
//
// Ports:
//   i_clk        clock, rising edge
//   i_clr_       synchronous active-low reset
//   i_start      start request, sampled only in IDLE
//   i_data       operand, captured on the start edge
//   i_amt        shift amount, captured on the start edge
//   i_leftRight  0 = left, 1 = right, captured on the start edge
//   i_mode       00 logical, 01 arithmetic, 10 rotate, 11 logical
//   o_data       working/result register
//   o_carry      last bit shifted out (or wrapped, for rotate)
//   o_busy       high while shifting
//   o_done       one-cycle completion pulse
module shift_seq #(
  parameter int nobit = 32,
  parameter int amtw  = 5
) (
  input  logic             i_clk,
  input  logic             i_clr_,
  input  logic             i_start,
  input  logic [nobit-1:0] i_data,
  input  logic [amtw-1:0]  i_amt,
  input  logic             i_leftRight,
  input  logic [1:0]       i_mode,
  output logic [nobit-1:0] o_data,
  output logic             o_carry,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {IDLE, SHIFT2, SHIFT1, DONE} state_t;

  state_t           state, state_nxt;
  logic [amtw-1:0]  count, count_nxt;
  logic [amtw-1:0]  rem2;
  logic             right_q, right_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [nobit-1:0] data_nxt;
  logic             carry_nxt;

  logic             rot, arith;
  logic [1:0]       fill_l2, fill_r2;
  logic             fill_l1, fill_r1;
  logic [nobit-1:0] shl2, shr2, shl1, shr1;

  // Candidate step results from the latched direction/mode. Mode 11 falls
  // through to logical because neither rot nor arith is set.
  always_comb begin
    rot     = (mode_q == 2'b10);
    arith   = (mode_q == 2'b01);
    // Left rotate: bit nobit-1 leaves first, so it lands in bit 1.
    fill_l2 = rot ? o_data[nobit-1:nobit-2] : 2'b00;
    fill_r2 = rot ? o_data[1:0] : (arith ? {2{o_data[nobit-1]}} : 2'b00);
    fill_l1 = rot & o_data[nobit-1];
    fill_r1 = rot ? o_data[0] : (arith & o_data[nobit-1]);
    shl2    = {o_data[nobit-3:0], fill_l2};
    shr2    = {fill_r2, o_data[nobit-1:2]};
    shl1    = {o_data[nobit-2:0], fill_l1};
    shr1    = {fill_r1, o_data[nobit-1:1]};
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    data_nxt  = o_data;
    carry_nxt = o_carry;
    right_nxt = right_q;
    mode_nxt  = mode_q;
    rem2      = count - amtw'(2);
    case (state)
      IDLE: begin
        if (i_start) begin
          data_nxt  = i_data;
          count_nxt = i_amt;
          carry_nxt = 1'b0;
          right_nxt = i_leftRight;
          mode_nxt  = i_mode;
          if (i_amt == '0)
            state_nxt = DONE;
          else if (i_amt == amtw'(1))
            state_nxt = SHIFT1;
          else
            state_nxt = SHIFT2;
        end
      end
      SHIFT2: begin
        data_nxt  = right_q ? shr2 : shl2;
        // Of the two bits leaving, the carry keeps the one that leaves last.
        carry_nxt = right_q ? o_data[1] : o_data[nobit-2];
        count_nxt = rem2;
        if (rem2 == '0)
          state_nxt = DONE;
        else if (rem2 == amtw'(1))
          state_nxt = SHIFT1;
      end
      SHIFT1: begin
        data_nxt  = right_q ? shr1 : shl1;
        carry_nxt = right_q ? o_data[0] : o_data[nobit-1];
        count_nxt = '0;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_) begin
      state   <= IDLE;
      count   <= '0;
      o_data  <= '0;
      o_carry <= 1'b0;
      right_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      o_data  <= data_nxt;
      o_carry <= carry_nxt;
      right_q <= right_nxt;
      mode_q  <= mode_nxt;
    end
  end

  assign o_busy = (state == SHIFT2) || (state == SHIFT1);
  assign o_done = (state == DONE);

endmodule
